load_writeback: RTL



---
 rtl/load_writeback.sv | 132 +++++++++++++
 1 files changed

// File: rtl/load_writeback.sv
// Multi-cycle load unit: fetches the containing word, aligns/extends/merges it,
// and issues a single-cycle register-file write (or an address-error pulse).
module load_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] rt_old,
    input  logic [4:0]  dest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic [1:0]  RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic        busy,
    output logic        done,
    output logic        addr_error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;

    logic [1:0]  r_state;
    logic [5:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_rt;
    logic [4:0]  r_dest;
    logic [31:0] r_wdata;

    logic        w_valid_op;
    logic        w_misaligned;
    logic [1:0]  w_k;
    logic [4:0]  w_sh_lane;
    logic [4:0]  w_sh_lwl;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_result;

    always_comb begin
        w_valid_op   = 1'b0;
        w_misaligned = 1'b0;
        case (opcode)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: w_valid_op = 1'b1;
            OP_LH, OP_LHU: begin
                w_valid_op   = 1'b1;
                w_misaligned = addr[0];
            end
            OP_LW: begin
                w_valid_op   = 1'b1;
                w_misaligned = (addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // Lane shifts: 8*k for the addressed byte / LWR, 8*(3-k) for LWL (3-k == ~k on 2 bits).
    assign w_k       = r_addr[1:0];
    assign w_sh_lane = {w_k, 3'b000};
    assign w_sh_lwl  = {~w_k, 3'b000};
    assign w_byte    = 8'(mem_readdata >> w_sh_lane);
    assign w_half    = r_addr[1] ? mem_readdata[31:16] : mem_readdata[15:0];

    always_comb begin
        w_result = mem_readdata;
        case (r_op)
            OP_LB:  w_result = {{24{w_byte[7]}}, w_byte};
            OP_LBU: w_result = {24'h000000, w_byte};
            OP_LH:  w_result = {{16{w_half[15]}}, w_half};
            OP_LHU: w_result = {16'h0000, w_half};
            OP_LWL: w_result = (mem_readdata << w_sh_lwl)
                             | (r_rt & ((32'd1 << w_sh_lwl) - 32'd1));
            OP_LWR: w_result = (mem_readdata >> w_sh_lane)
                             | (r_rt & ~(32'hFFFF_FFFF >> w_sh_lane));
            default: w_result = mem_readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= 6'd0;
            r_addr  <= 32'd0;
            r_rt    <= 32'd0;
            r_dest  <= 5'd0;
            r_wdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_valid_op) begin
                        r_op    <= opcode;
                        r_addr  <= addr;
                        r_rt    <= rt_old;
                        r_dest  <= dest;
                        r_state <= w_misaligned ? S_ERR : S_REQ;
                    end
                end
                S_REQ: begin
                    if (!mem_waitrequest) begin
                        r_wdata <= w_result;
                        r_state <= S_WB;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_address    = {r_addr[31:2], 2'b00};
    assign mem_read       = (r_state == S_REQ);
    assign mem_byteenable = {4{mem_read}};
    assign RegWrite       = (r_state == S_WB && r_dest != 5'd0) ? 2'b11 : 2'b00;
    assign WriteReg       = r_dest;
    assign WriteData      = r_wdata;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_WB);
    assign addr_error     = (r_state == S_ERR);

endmodule
